// File: rtl/mem_ctrl_simple.sv
// Block-granular main-memory controller: arbitrates icache (priority) and dcache
// requests and services one at a time against a fixed-latency internal store.
module mem_ctrl_simple #(
    parameter int unsigned MEM_N_BLOCKS = 1024,
    parameter int unsigned MEM_LATENCY  = 10,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 512
) (
    input  logic              clk,
    input  logic              rst_aL,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] icache_req_block_addr,
    output logic              icache_req_ready,
    input  logic              dcache_req_valid,
    input  logic              dcache_req_type,
    input  logic [ADDR_W-1:0] dcache_req_block_addr,
    input  logic [DATA_W-1:0] dcache_req_block_data,
    output logic              dcache_req_ready,
    output logic              icache_resp_valid,
    output logic              dcache_resp_valid,
    output logic [DATA_W-1:0] resp_block_data,
    input  logic              tb_wr_en,
    input  logic [ADDR_W-1:0] tb_wr_block_addr,
    input  logic [DATA_W-1:0] tb_wr_block_data
);
    localparam int unsigned IDX_W = $clog2(MEM_N_BLOCKS);
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { OWN_I, OWN_D } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem [MEM_N_BLOCKS];
    logic               done;
    logic               unused_addr_bits;

    // Upper block-address bits alias onto the store and are deliberately dropped.
    assign unused_addr_bits = ^{icache_req_block_addr[ADDR_W-1:IDX_W],
                                dcache_req_block_addr[ADDR_W-1:IDX_W],
                                tb_wr_block_addr[ADDR_W-1:IDX_W]};

    assign done = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (icache_req_valid) begin
                    owner_d = OWN_I;
                    wr_d    = 1'b0;
                    addr_d  = icache_req_block_addr[IDX_W-1:0];
                    data_d  = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end else if (dcache_req_valid) begin
                    owner_d = OWN_D;
                    wr_d    = dcache_req_type;
                    addr_d  = dcache_req_block_addr[IDX_W-1:0];
                    data_d  = dcache_req_block_data;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Preload only when IDLE with no valid request, since any valid request in IDLE is accepted.
    always_ff @(posedge clk) begin
        if (done && wr_q) begin
            mem[addr_q] <= data_q;
        end else if (tb_wr_en && (state_q == IDLE) && !icache_req_valid && !dcache_req_valid) begin
            mem[tb_wr_block_addr[IDX_W-1:0]] <= tb_wr_block_data;
        end
    end

    always_comb begin
        icache_req_ready  = (state_q == IDLE);
        dcache_req_ready  = (state_q == IDLE) && !icache_req_valid;
        icache_resp_valid = done && !wr_q && (owner_q == OWN_I);
        dcache_resp_valid = done && !wr_q && (owner_q == OWN_D);
        resp_block_data   = (done && !wr_q) ? mem[addr_q] : '0;
    end
endmodule

// File: tb/tb_mem_ctrl_simple.sv
// Scoreboard bench for mem_ctrl_simple: a latency-10 instance for the main
// scenarios and a latency-1 instance for the back-to-back throughput case.
module tb_mem_ctrl_simple;
    localparam int DW = 64;
    localparam logic [DW-1:0] PAT_A5   = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [DW-1:0] PAT_09   = 64'h0909_0909_0909_0909;
    localparam logic [DW-1:0] PAT_DEAD = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [DW-1:0] PAT_BAD  = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam logic [DW-1:0] PAT_U1   = 64'h1234_5678_9ABC_DEF0;

    typedef struct {
        logic          own_d;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          i_valid, i_ready, d_valid, d_type, d_ready;
    logic [31:0]   i_addr, d_addr, w_addr;
    logic [DW-1:0] d_data, w_data, r_data;
    logic          i_resp, d_resp, w_en;

    logic          u1_i_valid, u1_i_ready, u1_d_ready, u1_i_resp, u1_d_resp, u1_w_en;
    logic [31:0]   u1_i_addr, u1_w_addr;
    logic [DW-1:0] u1_r_data, u1_w_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_simple #(.MEM_N_BLOCKS(1024), .MEM_LATENCY(10), .ADDR_W(32), .DATA_W(DW)) u0 (
        .clk(clk), .rst_aL(rst_aL),
        .icache_req_valid(i_valid), .icache_req_block_addr(i_addr), .icache_req_ready(i_ready),
        .dcache_req_valid(d_valid), .dcache_req_type(d_type), .dcache_req_block_addr(d_addr),
        .dcache_req_block_data(d_data), .dcache_req_ready(d_ready),
        .icache_resp_valid(i_resp), .dcache_resp_valid(d_resp), .resp_block_data(r_data),
        .tb_wr_en(w_en), .tb_wr_block_addr(w_addr), .tb_wr_block_data(w_data)
    );

    mem_ctrl_simple #(.MEM_N_BLOCKS(1024), .MEM_LATENCY(1), .ADDR_W(32), .DATA_W(DW)) u1 (
        .clk(clk), .rst_aL(rst_aL),
        .icache_req_valid(u1_i_valid), .icache_req_block_addr(u1_i_addr), .icache_req_ready(u1_i_ready),
        .dcache_req_valid(1'b0), .dcache_req_type(1'b0), .dcache_req_block_addr(32'd0),
        .dcache_req_block_data('0), .dcache_req_ready(u1_d_ready),
        .icache_resp_valid(u1_i_resp), .dcache_resp_valid(u1_d_resp), .resp_block_data(u1_r_data),
        .tb_wr_en(u1_w_en), .tb_wr_block_addr(u1_w_addr), .tb_wr_block_data(u1_w_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_aL && (i_resp || d_resp)) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_resp", {62'd0, i_resp, d_resp}, 64'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("u0_resp_owner", {62'd0, i_resp, d_resp}, e.own_d ? 64'd1 : 64'd2);
                chk("u0_resp_data", r_data, e.data);
                chk("u0_resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_aL && (u1_i_resp || u1_d_resp)) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_resp", {62'd0, u1_i_resp, u1_d_resp}, 64'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("u1_resp_owner", {62'd0, u1_i_resp, u1_d_resp}, 64'd2);
                chk("u1_resp_data", u1_r_data, e.data);
                chk("u1_resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [DW-1:0] d);
        w_en = 1'b1; w_addr = a; w_data = d;
        @(posedge clk); #1;
        w_en = 1'b0;
    endtask

    // Drives one request until accepted; read expectations go to the scoreboard at acceptance.
    task automatic issue(input bit is_d, input bit wr, input logic [31:0] a,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data,
                         output int acc_cyc);
        bit ok = 1'b0;
        exp_t e;
        acc_cyc = -1;
        if (is_d) begin
            d_valid = 1'b1; d_type = wr; d_addr = a; d_data = wdata;
        end else begin
            i_valid = 1'b1; i_addr = a;
        end
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (is_d ? d_ready : i_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                if (!is_d && d_valid) chk("d_ready_blocked_by_i", {63'd0, d_ready}, 64'd0);
                if (is_d ? !wr : 1'b1) begin
                    e.own_d = is_d; e.data = exp_data; e.cyc = cyc + 10;
                    q0.push_back(e);
                end
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (is_d) d_valid = 1'b0;
        else i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int c, c2;
        rst_aL = 1'b0;
        i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_type = 1'b0; d_addr = '0; d_data = '0;
        w_en = 1'b0; w_addr = '0; w_data = '0;
        u1_i_valid = 1'b0; u1_i_addr = '0; u1_w_en = 1'b0; u1_w_addr = '0; u1_w_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_resp", {63'd0, i_resp}, 64'd0);
        chk("rst_d_resp", {63'd0, d_resp}, 64'd0);
        chk("rst_resp_data", r_data, 64'd0);
        chk("rst_i_ready", {63'd0, i_ready}, 64'd1);
        @(posedge clk); #1;
        rst_aL = 1'b1;

        preload(32'd5, PAT_A5);
        preload(32'd9, PAT_09);

        // Plain icache read of preloaded block 5.
        issue(1'b0, 1'b0, 32'd5, '0, PAT_A5, c);
        @(negedge clk);
        chk("busy_i_ready", {63'd0, i_ready}, 64'd0);
        drain();

        // Simultaneous requests: icache wins, dcache accepted right after icache completes.
        d_valid = 1'b1; d_type = 1'b0; d_addr = 32'd9; d_data = '0;
        issue(1'b0, 1'b0, 32'd5, '0, PAT_A5, c);
        issue(1'b1, 1'b0, 32'd9, '0, PAT_09, c2);
        chk("d_accept_after_i", 64'(c2), 64'(c + 11));
        drain();

        // Write then read-after-write on block 7.
        issue(1'b1, 1'b1, 32'd7, PAT_DEAD, '0, c);
        issue(1'b1, 1'b0, 32'd7, '0, PAT_DEAD, c2);
        chk("raw_accept_cycle", 64'(c2), 64'(c + 11));
        drain();

        // Reset 4 cycles into a write to block 9 drops the write.
        issue(1'b1, 1'b1, 32'd9, PAT_BAD, '0, c);
        repeat (3) @(posedge clk);
        #1 rst_aL = 1'b0;
        #1;
        chk("midrst_i_resp", {63'd0, i_resp}, 64'd0);
        chk("midrst_d_resp", {63'd0, d_resp}, 64'd0);
        chk("midrst_resp_data", r_data, 64'd0);
        chk("midrst_idle", {62'd0, i_ready, d_ready}, 64'd3);
        @(posedge clk); #1;
        rst_aL = 1'b1;
        issue(1'b1, 1'b0, 32'd9, '0, PAT_09, c);
        drain();

        // Upper address bits alias onto block 5.
        issue(1'b0, 1'b0, 32'h405, '0, PAT_A5, c);
        drain();

        // Latency-1 instance: continuous icache reads alternate accept / complete.
        u1_w_en = 1'b1; u1_w_addr = 32'd5; u1_w_data = PAT_U1;
        @(posedge clk); #1;
        u1_w_en = 1'b0;
        u1_i_valid = 1'b1; u1_i_addr = 32'd5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("u1_ready_%0d", k), {63'd0, u1_i_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
            if (u1_i_ready) begin
                exp_t e;
                e.own_d = 1'b0; e.data = PAT_U1; e.cyc = cyc + 1;
                q1.push_back(e);
            end
        end
        @(posedge clk); #1;
        u1_i_valid = 1'b0;
        drain();

        chk("u0_queue_empty", 64'(q0.size()), 64'd0);
        chk("u1_queue_empty", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_ctrl_simple.md
Name: mem_ctrl_simple

Overview:
- Main-memory controller sitting directly below the dcache inside the load/store unit and below the icache.
- Arbitrates block-granular read/write requests from both caches (icache has fixed priority) and services one request at a time against an internal block-addressed backing store with fixed latency.
- Returns read block data to the requesting cache as a one-cycle response pulse.

Parameters:
- MEM_N_BLOCKS, 1024, number of blocks in the backing store; index = low $clog2(MEM_N_BLOCKS) bits of main_mem_block_addr_t, upper bits ignored.
- MEM_LATENCY, 10, cycles from request acceptance to response/write commit; legal range >= 1.

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous active-low reset
- icache_req_valid  in  1  icache read request
- icache_req_block_addr  in  main_mem_block_addr_t  icache block address
- icache_req_ready  out  1  icache request accepted this cycle when high with valid
- dcache_req_valid  in  1  dcache request
- dcache_req_type  in  req_type_t  0 read, 1 write
- dcache_req_block_addr  in  main_mem_block_addr_t  dcache block address
- dcache_req_block_data  in  block_data_t  write data (writes only)
- dcache_req_ready  out  1  dcache request accepted
- icache_resp_valid  out  1  one-cycle read response to icache
- dcache_resp_valid  out  1  one-cycle read response to dcache
- resp_block_data  out  block_data_t  shared response data, valid only with a resp_valid
- tb_wr_en  in  1  testbench preload write, honoured only in IDLE with no accepted request
- tb_wr_block_addr  in  main_mem_block_addr_t  preload address
- tb_wr_block_data  in  block_data_t  preload data

Behaviour:
- State machine: IDLE, BUSY. Registered request: owner (ICACHE/DCACHE), type, block addr, write data; down-counter of width $clog2(MEM_LATENCY+1).
- Reset (async, rst_aL=0): state IDLE, counter 0, latched request cleared, both resp_valid 0, resp_block_data 0. Backing store contents are not reset.
- Ready is combinational:
  - icache_req_ready = (state==IDLE).
  - dcache_req_ready = (state==IDLE) & ~icache_req_valid.
  - icache always wins a simultaneous request; the dcache holds valid and retries.
- Accept:
  - Fires at the edge where valid&ready.
  - Latches the request, loads counter with MEM_LATENCY-1, goes to BUSY.
  - icache requests are always reads.
- BUSY:
  - Counter decrements each cycle.
  - The cycle the counter == 0 is the completion cycle.
  - Read completion: owner's resp_valid=1 for exactly that cycle; resp_block_data = store[addr], combinational from the array.
  - Write completion: store[addr] <= write data at the end of that cycle; no resp_valid pulse.
  - Next state IDLE.
- Latency:
  - Request accepted at edge T → response visible in cycle T+MEM_LATENCY.
  - Next request can be accepted at the edge after the completion cycle.
  - Back-to-back throughput is one request per MEM_LATENCY+1 cycles.
- MEM_LATENCY==1: BUSY lasts one cycle, which is the completion cycle.
- Requester valid/addr changes while BUSY are ignored; only latched values are used.
- Read-after-write to the same block returns the newly written data, since the write commits before IDLE.
- tb_wr_en:
  - Writes the store in IDLE when no request is accepted that cycle.
  - Ignored otherwise.
  - Never produces a response.
- Reset mid-BUSY: the transaction is dropped, no response, and a pending write is not committed.
- No flush input: in-flight transactions always complete; squashing is the caches' responsibility.

Test Plan:
- Preload block 5 = 0xA5 pattern via tb_wr_en. icache reads 5, accepted at edge T (MEM_LATENCY=10) → icache_resp_valid high only in cycle T+10 with resp_block_data = pattern; dcache_resp_valid stays 0.
- icache and dcache both valid in the same IDLE cycle → icache accepted, dcache_req_ready=0. dcache is accepted at the edge after icache completion; its response arrives 10 cycles later.
- dcache writes 0xDEAD… to block 7, then reads block 7 → no resp on the write; the read returns 0xDEAD…; total 22 cycles from first acceptance.
- Assert rst_aL low 4 cycles into a dcache write to block 9 → outputs 0, state IDLE, block 9 unchanged on a subsequent read.
- MEM_LATENCY=1 build: continuous icache reads → one response every 2 cycles; ready toggles 1,0,1,0.
- Block address with bits above index set (MEM_N_BLOCKS=1024, addr 0x405) → aliases to block 5 and returns block 5 data.
